processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor.sv | 159 +++++++++++++++
 tb/tb_processor.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
`timescale 1ns/1ps
// processor: 10-slot VLIW core executing one 320-bit bundle per cycle.
//   Slots 0-6 are R-format ALU/multiply ops, slot 7 is LW, slot 8 is LI and
//   slot 9 is SW.  Every slot reads register and data-memory state as it was
//   before the clock edge.  When several slots write the same register, the
//   highest-numbered slot wins.  Register 0 is hard-wired to zero.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset (pc and register file only)
//   run         1 = execute imem[pc] and advance pc; 0 = hold everything
//   imem_we     instruction-memory write enable (honoured regardless of run)
//   imem_addr   instruction-memory write address (64 bundles)
//   imem_wdata  320-bit bundle to write
//   dbg_raddr   register-file debug read address
//   dbg_rdata   combinational read of register dbg_raddr
//   pc          current program counter
module processor (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         imem_we,
    input  logic [5:0]   imem_addr,
    input  logic [319:0] imem_wdata,
    input  logic [4:0]   dbg_raddr,
    output logic [31:0]  dbg_rdata,
    output logic [5:0]   pc
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_MAC  = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_SRA  = 5'd8,
        OP_MUL  = 5'd9,
        OP_SLT  = 5'd10,
        OP_SLTU = 5'd11,
        OP_LW   = 5'd18,
        OP_LI   = 5'd19,
        OP_SW   = 5'd20
    } opcode_e;

    logic [319:0] imem [64];
    logic [31:0]  regs [32];
    logic [31:0]  dmem [256];

    logic [319:0] bundle;
    logic [31:0]  slot    [10];

    // Register write ports, one per register-writing slot (0-8).
    logic         wr_en   [9];
    logic [4:0]   wr_addr [9];
    logic [31:0]  wr_data [9];

    logic         sw_en;
    logic [7:0]   sw_addr;
    logic [31:0]  sw_data;

    // R-format evaluation; returns {valid, result}.  An all-zero word is a
    // NOP even though its opcode field decodes as ADD.
    function automatic logic [32:0] r_op(input logic [31:0] w,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b1;
        case (w[31:27])
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_MAC:  r = a * b + c;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_MUL:  r = a * b;
            OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: r = {31'b0, a < b};
            default: v = 1'b0;
        endcase
        if (w == '0) begin
            v = 1'b0;
        end
        return {v, r};
    endfunction

    assign bundle = imem[pc];

    for (genvar k = 0; k < 10; k++) begin : g_slot
        assign slot[k] = bundle[319 - 32*k -: 32];
    end

    for (genvar k = 0; k < 7; k++) begin : g_alu
        assign {wr_en[k], wr_data[k]} = r_op(slot[k],
                                             regs[slot[k][26:22]],
                                             regs[slot[k][21:17]],
                                             regs[slot[k][11:7]]);
        assign wr_addr[k] = slot[k][16:12];
    end

    always_comb begin
        wr_en[7]   = (slot[7] != '0) && (slot[7][31:27] == OP_LW);
        wr_addr[7] = slot[7][26:22];
        wr_data[7] = dmem[slot[7][7:0]];

        wr_en[8]   = (slot[8] != '0) && (slot[8][31:27] == OP_LI);
        wr_addr[8] = slot[8][4:0];
        wr_data[8] = {10'b0, slot[8][26:5]};

        sw_en      = (slot[9] != '0) && (slot[9][31:27] == OP_SW);
        sw_addr    = slot[9][7:0];
        sw_data    = regs[slot[9][26:22]];
    end

    // Slots are applied in ascending order so the last non-blocking write to
    // a register (highest slot) takes effect.  Data memory shares this block
    // but is left untouched by reset, so a bundle in flight when reset hits
    // never reaches memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else if (run) begin
            for (int unsigned k = 0; k < 9; k++) begin
                if (wr_en[k[3:0]] && (wr_addr[k[3:0]] != '0)) begin
                    regs[wr_addr[k[3:0]]] <= wr_data[k[3:0]];
                end
            end
            if (sw_en) begin
                dmem[sw_addr] <= sw_data;
            end
            pc <= pc + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    always_comb begin
        dbg_rdata = '0;
        if (dbg_raddr != '0) begin
            dbg_rdata = regs[dbg_raddr];
        end
    end

endmodule

// File: tb/tb_processor.sv
`timescale 1ns/1ps
// Scoreboard bench for processor: the stimulus process advances a reference
// model of the architectural state and queues expected pc/register values;
// the monitor process drains the queue at each falling clock edge (and on a
// falling reset edge), reading registers back through the debug port.
module tb_processor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         run;
    logic         imem_we;
    logic [5:0]   imem_addr;
    logic [319:0] imem_wdata;
    logic [4:0]   dbg_raddr;
    logic [31:0]  dbg_rdata;
    logic [5:0]   pc;

    processor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          is_pc;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference architectural state.
    logic [319:0] m_imem [64];
    logic [31:0]  m_reg  [32];
    logic [31:0]  m_dmem [256];
    bit           known  [256];
    logic [5:0]   m_pc;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] rw(int op, int rs1, int rs2, int rd, int rs3);
        return {op[4:0], rs1[4:0], rs2[4:0], rd[4:0], rs3[4:0], 7'b0};
    endfunction

    function automatic logic [31:0] mw(int op, int r, int addr);
        return {op[4:0], r[4:0], addr[21:0]};
    endfunction

    function automatic logic [31:0] iw(int imm, int rd);
        return {5'd19, imm[21:0], rd[4:0]};
    endfunction

    function automatic logic [319:0] put(logic [319:0] b, int k, logic [31:0] w);
        b[319 - 32*k -: 32] = w;
        return b;
    endfunction

    function automatic int rnd_reg();
        return int'($urandom_range(0, 31));
    endfunction

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
    endfunction

    function automatic void model_exec();
        logic [319:0] b;
        logic [31:0]  w, a, bv, c, res;
        logic [4:0]   op;
        bit           wen  [10];
        logic [4:0]   wad  [10];
        logic [31:0]  wval [10];
        bit           sw;
        logic [7:0]   sw_a;
        logic [31:0]  sw_v;
        int           sa, sh;
        b = m_imem[m_pc];
        sw = 0; sw_a = '0; sw_v = '0;
        for (int k = 0; k < 10; k++) begin
            w = b[319 - 32*k -: 32];
            op = w[31:27];
            wen[k] = 0; wad[k] = '0; wval[k] = '0;
            if (w != '0) begin
                if (k <= 6 && op <= 5'd11) begin
                    a  = m_reg[w[26:22]];
                    bv = m_reg[w[21:17]];
                    c  = m_reg[w[11:7]];
                    sa = int'(a);
                    sh = int'(bv[4:0]);
                    res = '0;
                    case (op)
                        5'd0:  res = a + bv;
                        5'd1:  res = a - bv;
                        5'd2:  res = a & bv;
                        5'd3:  res = a | bv;
                        5'd4:  res = a * bv + c;
                        5'd5:  res = a ^ bv;
                        5'd6:  res = a << sh;
                        5'd7:  res = a >> sh;
                        5'd8:  res = 32'(sa >>> sh);
                        5'd9:  res = a * bv;
                        5'd10: res = (sa < int'(bv)) ? 32'd1 : 32'd0;
                        default: res = (a < bv) ? 32'd1 : 32'd0;
                    endcase
                    wen[k] = 1; wad[k] = w[16:12]; wval[k] = res;
                end else if (k == 7 && op == 5'd18) begin
                    wen[k] = 1; wad[k] = w[26:22]; wval[k] = m_dmem[w[7:0]];
                end else if (k == 8 && op == 5'd19) begin
                    wen[k] = 1; wad[k] = w[4:0]; wval[k] = {10'b0, w[26:5]};
                end else if (k == 9 && op == 5'd20) begin
                    sw = 1; sw_a = w[7:0]; sw_v = m_reg[w[26:22]];
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (wen[k] && wad[k] != 5'd0) m_reg[wad[k]] = wval[k];
        end
        if (sw) begin
            m_dmem[sw_a] = sw_v;
            known[sw_a]  = 1;
        end
        m_pc = m_pc + 6'd1;
    endfunction

    function automatic void model_edge();
        if (!rst_n)   model_reset();
        else if (run) model_exec();
        if (imem_we)  m_imem[imem_addr] = imem_wdata;
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic void push_pc(logic [5:0] v);
        exp_t e;
        e.is_pc = 1; e.idx = '0; e.val = {26'b0, v};
        q.push_back(e);
    endfunction

    function automatic void push_reg(int r, logic [31:0] v);
        exp_t e;
        e.is_pc = 0; e.idx = r[4:0]; e.val = v;
        q.push_back(e);
    endfunction

    function automatic void push_all();
        push_pc(m_pc);
        for (int i = 0; i < 32; i++) push_reg(i, m_reg[i]);
    endfunction

    function automatic logic [319:0] rand_bundle();
        logic [319:0] b;
        logic [31:0]  w;
        int           a;
        b = '0;
        for (int k = 0; k < 7; k++) begin
            case ($urandom_range(0, 9))
                0: w = '0;
                1: w = $urandom();
                default: begin
                    w = rw(int'($urandom_range(0, 11)), rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg());
                    w[6:0] = 7'($urandom());
                end
            endcase
            b = put(b, k, w);
        end
        w = '0;
        case ($urandom_range(0, 3))
            0: w = '0;
            1: begin
                w = $urandom();
                if (w[31:27] == 5'd18) w[31:27] = 5'd21;
            end
            default: begin
                for (int t = 0; t < 8; t++) begin
                    a = int'($urandom_range(0, 255));
                    if (known[a]) begin
                        w = mw(18, rnd_reg(), int'($urandom_range(0, 16383)) * 256 + a);
                        break;
                    end
                end
            end
        endcase
        b = put(b, 7, w);
        if ($urandom_range(0, 1) == 1)
            b = put(b, 8, iw(int'($urandom_range(0, 4194303)), rnd_reg()));
        case ($urandom_range(0, 3))
            0: w = '0;
            1: w = $urandom();
            default: w = mw(20, rnd_reg(), int'($urandom_range(0, 4194303)));
        endcase
        b = put(b, 9, w);
        return b;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        push_all();
    endtask

    task automatic load(int a, logic [319:0] b);
        run        = 1'b0;
        imem_we    = 1'b1;
        imem_addr  = a[5:0];
        imem_wdata = b;
        step();
        imem_we    = 1'b0;
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic reset_pulse();
        @(negedge clk);
        #4;
        model_reset();
        push_all();
        rst_n = 1'b0;
        #4.5;
        rst_n = 1'b1;
    endtask

    // Reset asserted while running and held across one rising edge.
    task automatic mid_reset();
        @(negedge clk);
        #4;
        model_reset();
        push_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        dbg_raddr = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.is_pc) begin
                    #0.05;
                    checks++;
                    if (pc !== e.val[5:0]) begin
                        errors++;
                        $display("FAIL pc at %0t: got %0d, expected %0d", $time, pc, e.val[5:0]);
                    end
                end else begin
                    dbg_raddr = e.idx;
                    #0.05;
                    checks++;
                    if (dbg_rdata !== e.val) begin
                        errors++;
                        $display("FAIL r%0d at %0t: got 0x%08h, expected 0x%08h",
                                 e.idx, $time, dbg_rdata, e.val);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        for (int i = 0; i < 64; i++)  m_imem[i] = '0;
        for (int i = 0; i < 256; i++) begin m_dmem[i] = '0; known[i] = 0; end
        model_reset();
        #1;
        push_all();
        @(negedge clk);
        #4;
        rst_n = 1'b1;

        for (int a = 0; a < 64; a++) load(a, '0);

        // LI into r22
        load(0, put('0, 8, iw(3524, 22)));
        run = 1'b1; step(); run = 1'b0;
        push_reg(22, 32'd3524); push_pc(6'd1);

        // parallel read: ADD sees r1 before the LI in the same bundle
        load(1, put(put('0, 8, iw(5, 1)), 0, rw(0, 1, 2, 3, 0)));
        load(2, put('0, 0, rw(0, 1, 1, 3, 0)));
        run = 1'b1;
        step(); push_reg(3, 32'd0); push_reg(1, 32'd5);
        step(); push_reg(3, 32'd10);
        run = 1'b0;

        // memory: SW to 524 aliases word 12
        load(3, put('0, 8, iw(2000, 4)));
        load(4, put('0, 9, mw(20, 4, 524)));
        load(5, put('0, 7, mw(18, 8, 12)));
        run = 1'b1; repeat (3) step(); run = 1'b0;
        push_reg(8, 32'd2000);

        // write conflict (slot 1 wins) and r0 immutability
        load(6, put(put('0, 0, rw(0, 1, 1, 5, 0)), 1, rw(1, 1, 0, 5, 0)));
        load(7, put('0, 8, iw(7, 0)));
        run = 1'b1; repeat (2) step(); run = 1'b0;
        push_reg(5, 32'd5); push_reg(0, 32'd0);

        // run=0 holds everything, then the same bundles execute
        load(8, put(put('0, 7, mw(18, 10, 12)), 8, iw(77, 11)));
        load(9, put('0, 9, mw(20, 3, 12)));
        load(10, put('0, 7, mw(18, 12, 12)));
        run = 1'b0; repeat (3) step();
        push_pc(6'd8); push_reg(10, 32'd0); push_reg(11, 32'd0);
        run = 1'b1; repeat (3) step(); run = 1'b0;
        push_reg(10, 32'd2000); push_reg(11, 32'd77); push_reg(12, 32'd10); push_pc(6'd11);

        // asynchronous reset without a clock edge
        reset_pulse();

        // 64 edges from pc=0 wrap back to 0
        run = 1'b1; repeat (64) step(); run = 1'b0;
        push_pc(6'd0);

        // randomized programs, including live imem rewrites and a mid-run reset
        for (int a = 0; a < 64; a++) load(a, rand_bundle());
        for (int it = 0; it < 400; it++) begin
            run     = ($urandom_range(0, 9) != 0);
            imem_we = ($urandom_range(0, 7) == 0);
            if (imem_we) begin
                imem_addr  = ($urandom_range(0, 1) == 1) ? m_pc : 6'($urandom_range(0, 63));
                imem_wdata = rand_bundle();
            end
            step();
            if (it == 200) begin
                run     = 1'b1;
                imem_we = 1'b0;
                mid_reset();
            end
        end
        run     = 1'b0;
        imem_we = 1'b0;

        repeat (2) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
